// File: rtl/buffer_page_writer.sv
// buffer_page_writer: unpacks source bytes MSB-first into single-bit
// outbuffer writes for a bootloader region or a user page.
//
// Ports:
//   MCLK, nRESET         clock, async active-low reset
//   BITWIDTH4            4-bit mode (doubles start address and bit total)
//   LOADSTART, LOADTYPE  load request and region select (0 boot, 1 user)
//   LOADABORT            synchronous abort of a running load
//   BYTEDATA, BYTEVALID  source byte and its valid flag
//   BYTEREADY            block accepts a byte this cycle
//   nOUTBUFWRCLKEN       outbuffer write strobe, active-low
//   OUTBUFWRADDR/DATA    outbuffer write address and bit
//   LOADBUSY, LOADDONE   load in progress / one-cycle completion pulse
module buffer_page_writer #(
    parameter int BOOT_BITS = 3854,
    parameter int USER_BASE = 14336,
    parameter int USER_BITS = 1168
) (
    input  logic        MCLK,
    input  logic        nRESET,
    input  logic        BITWIDTH4,
    input  logic        LOADSTART,
    input  logic        LOADTYPE,
    input  logic        LOADABORT,
    input  logic [7:0]  BYTEDATA,
    input  logic        BYTEVALID,
    output logic        BYTEREADY,
    output logic        nOUTBUFWRCLKEN,
    output logic [14:0] OUTBUFWRADDR,
    output logic        OUTBUFWRDATA,
    output logic        LOADBUSY,
    output logic        LOADDONE
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_BYTE,
        SHIFT,
        DONE
    } state_t;

    localparam logic [14:0] USER_ADDR = 15'(USER_BASE);
    localparam logic [15:0] BOOT_TOT  = 16'(BOOT_BITS);
    localparam logic [15:0] USER_TOT  = 16'(USER_BITS);

    state_t      state;
    state_t      state_nx;
    logic [14:0] addr_q;
    logic [14:0] addr_nx;
    logic [15:0] cnt_q;
    logic [15:0] cnt_nx;
    logic [15:0] total_q;
    logic [15:0] total_nx;
    logic [7:0]  sh_q;
    logic [7:0]  sh_nx;
    logic [2:0]  idx_q;
    logic [2:0]  idx_nx;
    logic        wr_n_nx;
    logic [14:0] wr_addr_nx;
    logic        wr_data_nx;
    logic        emit;
    logic [7:0]  src;
    logic [14:0] base;
    logic [15:0] tot;

    always_comb begin
        state_nx   = state;
        addr_nx    = addr_q;
        cnt_nx     = cnt_q;
        total_nx   = total_q;
        sh_nx      = sh_q;
        idx_nx     = idx_q;
        wr_n_nx    = 1'b1;
        wr_addr_nx = OUTBUFWRADDR;
        wr_data_nx = OUTBUFWRDATA;
        emit       = 1'b0;
        src        = sh_q;
        base       = LOADTYPE ? USER_ADDR : 15'd0;
        tot        = LOADTYPE ? USER_TOT : BOOT_TOT;

        unique case (state)
            IDLE: begin
                if (LOADSTART) begin
                    state_nx = WAIT_BYTE;
                    addr_nx  = BITWIDTH4 ? (base << 1) : base;
                    total_nx = BITWIDTH4 ? (tot << 1) : tot;
                    cnt_nx   = 16'd0;
                    idx_nx   = 3'd0;
                    sh_nx    = 8'd0;
                end
            end
            WAIT_BYTE: begin
                if (BYTEVALID && BYTEREADY) begin
                    src      = BYTEDATA;
                    emit     = 1'b1;
                    state_nx = SHIFT;
                end
            end
            SHIFT: begin
                // The strobe for the bit scheduled last cycle is on the
                // outputs now; decide what follows it.
                if (cnt_q == total_q) begin
                    state_nx = DONE;
                end else if (idx_q == 3'd0) begin
                    state_nx = WAIT_BYTE;
                end else begin
                    emit = 1'b1;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        if (emit) begin
            wr_n_nx    = 1'b0;
            wr_addr_nx = addr_q;
            wr_data_nx = src[7];
            sh_nx      = {src[6:0], 1'b0};
            addr_nx    = addr_q + 15'd1;
            cnt_nx     = cnt_q + 16'd1;
            idx_nx     = idx_q + 3'd1;
        end

        if (LOADABORT && state != IDLE) begin
            state_nx   = IDLE;
            wr_n_nx    = 1'b1;
            wr_addr_nx = OUTBUFWRADDR;
            wr_data_nx = OUTBUFWRDATA;
        end
    end

    always_ff @(posedge MCLK or negedge nRESET) begin
        if (!nRESET) begin
            state          <= IDLE;
            addr_q         <= 15'd0;
            cnt_q          <= 16'd0;
            total_q        <= 16'd0;
            sh_q           <= 8'd0;
            idx_q          <= 3'd0;
            nOUTBUFWRCLKEN <= 1'b1;
            OUTBUFWRADDR   <= 15'd0;
            OUTBUFWRDATA   <= 1'b0;
            BYTEREADY      <= 1'b0;
            LOADBUSY       <= 1'b0;
            LOADDONE       <= 1'b0;
        end else begin
            state          <= state_nx;
            addr_q         <= addr_nx;
            cnt_q          <= cnt_nx;
            total_q        <= total_nx;
            sh_q           <= sh_nx;
            idx_q          <= idx_nx;
            nOUTBUFWRCLKEN <= wr_n_nx;
            OUTBUFWRADDR   <= wr_addr_nx;
            OUTBUFWRDATA   <= wr_data_nx;
            BYTEREADY      <= (state_nx == WAIT_BYTE);
            LOADBUSY       <= (state_nx != IDLE);
            LOADDONE       <= (state_nx == DONE);
        end
    end

endmodule

// File: tb/tb_buffer_page_writer.sv
// tb_buffer_page_writer: directed bench for buffer_page_writer.
// Ports: none; drives the DUT and prints one summary line.
module tb_buffer_page_writer;

    logic        MCLK;
    logic        nRESET;
    logic        BITWIDTH4;
    logic        LOADSTART;
    logic        LOADTYPE;
    logic        LOADABORT;
    logic [7:0]  BYTEDATA;
    logic        BYTEVALID;
    logic        BYTEREADY;
    logic        nOUTBUFWRCLKEN;
    logic [14:0] OUTBUFWRADDR;
    logic        OUTBUFWRDATA;
    logic        LOADBUSY;
    logic        LOADDONE;

    int checks;
    int errors;

    int r_strobes, r_first, r_last, r_bytes, r_dones;
    int r_contig, r_data, r_wait, r_after, r_first_cyc;
    int r_last_cyc, r_done_cyc, r_post_abort;
    bit r_timeout;

    buffer_page_writer dut (
        .MCLK(MCLK),
        .nRESET(nRESET),
        .BITWIDTH4(BITWIDTH4),
        .LOADSTART(LOADSTART),
        .LOADTYPE(LOADTYPE),
        .LOADABORT(LOADABORT),
        .BYTEDATA(BYTEDATA),
        .BYTEVALID(BYTEVALID),
        .BYTEREADY(BYTEREADY),
        .nOUTBUFWRCLKEN(nOUTBUFWRCLKEN),
        .OUTBUFWRADDR(OUTBUFWRADDR),
        .OUTBUFWRDATA(OUTBUFWRDATA),
        .LOADBUSY(LOADBUSY),
        .LOADDONE(LOADDONE)
    );

    initial MCLK = 1'b0;
    always #5 MCLK = ~MCLK;

    function automatic logic [7:0] byte_val(int mode, int i);
        if (mode == 0) return 8'hA5;
        return 8'(i * 37 + 11);
    endfunction

    // Runs one load and gathers statistics; the test tasks judge them.
    task automatic run_load(input logic ltype, input logic w4,
                            input int gapmode, input int dmode,
                            input int abort_at, input int restart_at);
        int cyc;
        int gap_left;
        int tail;
        bit ab;
        logic [7:0] cur;
        r_strobes = 0; r_first = -1; r_last = -1; r_bytes = 0;
        r_dones = 0; r_contig = 0; r_data = 0; r_wait = 0;
        r_after = 0; r_first_cyc = -1; r_last_cyc = -1;
        r_done_cyc = -1; r_post_abort = 0; r_timeout = 0;
        cyc = 0; gap_left = 0; tail = -1; ab = 0;
        @(posedge MCLK); #1;
        LOADSTART = 1'b1; LOADTYPE = ltype; BITWIDTH4 = w4;
        BYTEVALID = 1'b0;
        while (1) begin
            @(posedge MCLK); #1;
            cyc++;
            LOADSTART = 1'b0;
            LOADABORT = 1'b0;
            if (ab && (nOUTBUFWRCLKEN !== 1'b1 || LOADBUSY !== 1'b0 ||
                       BYTEREADY !== 1'b0 || LOADDONE !== 1'b0))
                r_post_abort++;
            if (nOUTBUFWRCLKEN === 1'b0) begin
                if (r_strobes == 0) begin
                    r_first = int'(OUTBUFWRADDR);
                    r_first_cyc = cyc;
                end else if (OUTBUFWRADDR !== 15'(r_last + 1)) begin
                    r_contig++;
                end
                cur = byte_val(dmode, r_strobes / 8);
                if (OUTBUFWRDATA !== cur[7 - (r_strobes % 8)]) r_data++;
                if (BYTEREADY === 1'b1) r_wait++;
                if (r_dones > 0) r_after++;
                r_last = int'(OUTBUFWRADDR);
                r_last_cyc = cyc;
                r_strobes++;
                if (r_strobes == abort_at) begin
                    LOADABORT = 1'b1; ab = 1; tail = 20;
                end
                if (r_strobes == restart_at) begin
                    LOADSTART = 1'b1;
                    LOADTYPE = ~ltype;
                    BITWIDTH4 = ~w4;
                end
            end
            if (LOADDONE === 1'b1) begin
                r_dones++;
                r_done_cyc = cyc;
                if (tail < 0) tail = 5;
            end
            if (BYTEREADY === 1'b1 && gap_left > 0) begin
                BYTEVALID = 1'b0;
                gap_left--;
            end else begin
                BYTEVALID = 1'b1;
                BYTEDATA = byte_val(dmode, r_bytes);
            end
            if (BYTEVALID === 1'b1 && BYTEREADY === 1'b1) begin
                r_bytes++;
                if (gapmode != 0) gap_left = (r_bytes * 7) % 6;
            end
            if (tail >= 0) begin
                if (tail == 0) break;
                tail--;
            end
            if (cyc >= 20000) begin
                r_timeout = 1;
                break;
            end
        end
        BYTEVALID = 1'b0;
        LOADSTART = 1'b0;
        LOADABORT = 1'b0;
    endtask

    task automatic test_reset();
        nRESET = 1'b0;
        repeat (3) @(posedge MCLK);
        #1;
        checks++;
        if (nOUTBUFWRCLKEN !== 1'b1) begin
            errors++;
            $display("FAIL reset_wr_n got %b want 1", nOUTBUFWRCLKEN);
        end
        checks++;
        if (OUTBUFWRADDR !== 15'd0) begin
            errors++;
            $display("FAIL reset_addr got %0d want 0", OUTBUFWRADDR);
        end
        checks++;
        if (OUTBUFWRDATA !== 1'b0 || BYTEREADY !== 1'b0) begin
            errors++;
            $display("FAIL reset_data_ready got %b%b want 00",
                     OUTBUFWRDATA, BYTEREADY);
        end
        checks++;
        if (LOADBUSY !== 1'b0 || LOADDONE !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy_done got %b%b want 00",
                     LOADBUSY, LOADDONE);
        end
        nRESET = 1'b1;
        repeat (4) @(posedge MCLK);
        #1;
        checks++;
        if (LOADBUSY !== 1'b0 || nOUTBUFWRCLKEN !== 1'b1) begin
            errors++;
            $display("FAIL reset_idle got busy=%b wr_n=%b want 0 1",
                     LOADBUSY, nOUTBUFWRCLKEN);
        end
    endtask

    task automatic test_boot2();
        run_load(1'b0, 1'b0, 0, 0, -1, -1);
        checks++;
        if (r_timeout || r_strobes != 3854) begin
            errors++;
            $display("FAIL boot2_strobes got %0d to=%0d want 3854",
                     r_strobes, r_timeout);
        end
        checks++;
        if (r_first != 0 || r_last != 3853) begin
            errors++;
            $display("FAIL boot2_range got %0d..%0d want 0..3853",
                     r_first, r_last);
        end
        checks++;
        if (r_contig != 0 || r_data != 0) begin
            errors++;
            $display("FAIL boot2_pattern got gaps=%0d bad=%0d want 0 0",
                     r_contig, r_data);
        end
        checks++;
        if (r_bytes != 482) begin
            errors++;
            $display("FAIL boot2_bytes got %0d want 482", r_bytes);
        end
        checks++;
        if (r_dones != 1 || r_done_cyc != r_last_cyc + 1 || r_after != 0) begin
            errors++;
            $display("FAIL boot2_done got n=%0d at %0d last %0d want 1 at last+1",
                     r_dones, r_done_cyc, r_last_cyc);
        end
        checks++;
        if (r_first_cyc != 2) begin
            errors++;
            $display("FAIL boot2_latency got %0d want 2", r_first_cyc);
        end
        checks++;
        if (LOADBUSY !== 1'b0 || nOUTBUFWRCLKEN !== 1'b1) begin
            errors++;
            $display("FAIL boot2_end_idle got busy=%b wr_n=%b want 0 1",
                     LOADBUSY, nOUTBUFWRCLKEN);
        end
    endtask

    task automatic test_user4();
        run_load(1'b1, 1'b1, 0, 1, -1, -1);
        checks++;
        if (r_timeout || r_strobes != 2336) begin
            errors++;
            $display("FAIL user4_strobes got %0d want 2336", r_strobes);
        end
        checks++;
        if (r_first != 28672 || r_last != 31007) begin
            errors++;
            $display("FAIL user4_range got %0d..%0d want 28672..31007",
                     r_first, r_last);
        end
        checks++;
        if (r_bytes != 292 || r_dones != 1) begin
            errors++;
            $display("FAIL user4_bytes got %0d done=%0d want 292 1",
                     r_bytes, r_dones);
        end
        checks++;
        if (r_contig != 0 || r_data != 0) begin
            errors++;
            $display("FAIL user4_data got gaps=%0d bad=%0d want 0 0",
                     r_contig, r_data);
        end
    endtask

    task automatic test_backpressure();
        run_load(1'b0, 1'b0, 1, 1, -1, -1);
        checks++;
        if (r_timeout || r_strobes != 3854 || r_bytes != 482) begin
            errors++;
            $display("FAIL bp_counts got %0d/%0d want 3854/482",
                     r_strobes, r_bytes);
        end
        checks++;
        if (r_contig != 0 || r_wait != 0) begin
            errors++;
            $display("FAIL bp_contig got gaps=%0d wait=%0d want 0 0",
                     r_contig, r_wait);
        end
        checks++;
        if (r_data != 0) begin
            errors++;
            $display("FAIL bp_order got bad=%0d want 0", r_data);
        end
    endtask

    task automatic test_abort();
        run_load(1'b0, 1'b0, 0, 0, 83, -1);
        checks++;
        if (r_strobes != 83 || r_last != 82) begin
            errors++;
            $display("FAIL abort_stop got %0d last %0d want 83 82",
                     r_strobes, r_last);
        end
        checks++;
        if (r_post_abort != 0) begin
            errors++;
            $display("FAIL abort_idle got %0d bad cycles want 0",
                     r_post_abort);
        end
        checks++;
        if (r_dones != 0) begin
            errors++;
            $display("FAIL abort_nodone got %0d want 0", r_dones);
        end
        run_load(1'b0, 1'b0, 0, 0, -1, -1);
        checks++;
        if (r_first != 0 || r_strobes != 3854 || r_dones != 1) begin
            errors++;
            $display("FAIL abort_restart got %0d n=%0d want 0 3854",
                     r_first, r_strobes);
        end
    endtask

    task automatic test_busy_start();
        run_load(1'b0, 1'b0, 0, 0, -1, 20);
        checks++;
        if (r_first != 0 || r_last != 3853 || r_strobes != 3854) begin
            errors++;
            $display("FAIL busy_start got %0d..%0d n=%0d want 0..3853",
                     r_first, r_last, r_strobes);
        end
        checks++;
        if (r_contig != 0 || r_data != 0 || r_dones != 1) begin
            errors++;
            $display("FAIL busy_start_seq got gaps=%0d bad=%0d d=%0d want 0 0 1",
                     r_contig, r_data, r_dones);
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        int bad;
        seen = 0;
        bad = 0;
        LOADTYPE = 1'b0;
        BITWIDTH4 = 1'b0;
        BYTEDATA = 8'hFF;
        @(posedge MCLK); #1;
        LOADSTART = 1'b1;
        BYTEVALID = 1'b1;
        for (int i = 0; i < 100 && seen < 5; i++) begin
            @(posedge MCLK); #1;
            LOADSTART = 1'b0;
            if (nOUTBUFWRCLKEN === 1'b0) seen++;
        end
        checks++;
        if (seen != 5 || nOUTBUFWRCLKEN !== 1'b0) begin
            errors++;
            $display("FAIL rmid_reach got %0d wr_n=%b want 5 0",
                     seen, nOUTBUFWRCLKEN);
        end
        #2;
        nRESET = 1'b0;
        #1;
        checks++;
        if (nOUTBUFWRCLKEN !== 1'b1 || OUTBUFWRADDR !== 15'd0 ||
            OUTBUFWRDATA !== 1'b0) begin
            errors++;
            $display("FAIL rmid_async_wr got %b %0d %b want 1 0 0",
                     nOUTBUFWRCLKEN, OUTBUFWRADDR, OUTBUFWRDATA);
        end
        checks++;
        if (LOADBUSY !== 1'b0 || BYTEREADY !== 1'b0 || LOADDONE !== 1'b0) begin
            errors++;
            $display("FAIL rmid_async_ctl got %b%b%b want 000",
                     LOADBUSY, BYTEREADY, LOADDONE);
        end
        @(posedge MCLK); #1;
        nRESET = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(posedge MCLK); #1;
            if (nOUTBUFWRCLKEN !== 1'b1 || LOADBUSY !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL rmid_stay_idle got %0d bad cycles want 0", bad);
        end
        BYTEVALID = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        nRESET = 1'b0;
        BITWIDTH4 = 1'b0;
        LOADSTART = 1'b0;
        LOADTYPE = 1'b0;
        LOADABORT = 1'b0;
        BYTEDATA = 8'd0;
        BYTEVALID = 1'b0;
        test_reset();
        test_boot2();
        test_user4();
        test_backpressure();
        test_abort();
        test_busy_start();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/buffer_page_writer.md
BUFFER_PAGE_WRITER -- requirements
Module: buffer_page_writer

Interface
REQ-001 SHALL have parameter BOOT_BITS, default 3854, meaning bootloader-region bit count in 2-bit mode (positions 0-1926, two channels).
REQ-002 SHALL have parameter USER_BASE, default 14336, meaning user-page start write address in 2-bit mode (position 7168 x 2).
REQ-003 SHALL have parameter USER_BITS, default 1168, meaning user-page bit count in 2-bit mode (584 positions x 2).
REQ-004 SHALL have port MCLK  in  1  48 MHz clock; the only clock in the block.
REQ-005 SHALL have port nRESET  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port BITWIDTH4  in  1  4-bit width mode when 1.
REQ-007 SHALL have port LOADSTART  in  1  one-cycle load request.
REQ-008 SHALL have port LOADTYPE  in  1  0 = bootloader region, 1 = user page.
REQ-009 SHALL have port LOADABORT  in  1  synchronous abort.
REQ-010 SHALL have port BYTEDATA  in  8  source byte.
REQ-011 SHALL have port BYTEVALID  in  1  source byte valid.
REQ-012 SHALL have port BYTEREADY  out  1  block accepts a byte.
REQ-013 SHALL have port nOUTBUFWRCLKEN  out  1  outbuffer write strobe, active-low.
REQ-014 SHALL have port OUTBUFWRADDR  out  15  outbuffer write address.
REQ-015 SHALL have port OUTBUFWRDATA  out  1  outbuffer write bit.
REQ-016 SHALL have port LOADBUSY  out  1  load in progress.
REQ-017 SHALL have port LOADDONE  out  1  one-cycle completion pulse.

Function
REQ-018 SHALL implement states IDLE, WAIT_BYTE, SHIFT and DONE.
REQ-019 SHALL register every output.
REQ-020 IDLE: on LOADSTART=1, SHALL latch LOADTYPE and BITWIDTH4, load the start address and bit total, and go to WAIT_BYTE on the next cycle.
REQ-021 Start address SHALL be 0 for boot and USER_BASE for user, shifted left by 1 when BITWIDTH4=1.
REQ-022 Bit total SHALL be BOOT_BITS or USER_BITS, shifted left by 1 when BITWIDTH4=1.
REQ-023 LOADBUSY SHALL be 1 in WAIT_BYTE, SHIFT and DONE, and 0 in IDLE.
REQ-024 BYTEREADY SHALL be 1 only in WAIT_BYTE; a byte is accepted on a cycle with BYTEVALID=1 and BYTEREADY=1.
REQ-025 On acceptance in cycle N, SHALL load the shift register and enter SHIFT; BYTEREADY SHALL be 0 from cycle N+1.
REQ-026 SHIFT, per cycle: nOUTBUFWRCLKEN=0, OUTBUFWRDATA = current bit (MSB first), OUTBUFWRADDR = current address; the address and bit count then each increment by 1.
REQ-027 An accepted byte SHALL therefore produce strobes in cycles N+1..N+8 at consecutive addresses.
REQ-028 After the 8th bit with the bit total not yet reached, SHALL return to WAIT_BYTE, with BYTEREADY=1 in cycle N+9.
REQ-029 When the bit count reaches the total (including mid-byte), SHALL discard the remaining bits of that byte and enter DONE.
REQ-030 Total-reached rule: 3854 bits gives 482 bytes with the last 2 bits dropped; 7708 bits gives 964 bytes with the last 4 bits dropped.
REQ-031 DONE SHALL last exactly one cycle with LOADDONE=1, then go to IDLE.
REQ-032 Outside SHIFT, nOUTBUFWRCLKEN SHALL be 1; OUTBUFWRADDR and OUTBUFWRDATA SHALL hold their last values.
REQ-033 LOADSTART while LOADBUSY=1 SHALL be ignored.
REQ-034 BYTEVALID while BYTEREADY=0 SHALL NOT be consumed.
REQ-035 LOADABORT=1 in any non-IDLE state SHALL go to IDLE next cycle, with nOUTBUFWRCLKEN=1, BYTEREADY=0, and no LOADDONE pulse.
REQ-036 LOADABORT SHALL take priority over LOADSTART and over byte acceptance in the same cycle.
REQ-037 The address counter SHALL be 15 bits and wrap 32767 -> 0; default parameters never reach the wrap.
REQ-038 Changes to BITWIDTH4 or LOADTYPE during a load SHALL have no effect until the next LOADSTART.

Reset
REQ-039 nRESET=0 SHALL asynchronously force: state IDLE, nOUTBUFWRCLKEN=1, OUTBUFWRADDR=0, OUTBUFWRDATA=0, BYTEREADY=0, LOADBUSY=0, LOADDONE=0, internal counters and shift register 0.
REQ-040 Reset asserted mid-load SHALL abandon the load and emit no further strobes.
REQ-041 After reset release, the block SHALL stay in IDLE until a new LOADSTART.

Verification
REQ-042 Boot, 2-bit: LOADSTART, LOADTYPE=0, bytes 0xA5 always valid -> 3854 strobes, addresses 0..3853, bit pattern 1,0,1,0,0,1,0,1 repeating; one LOADDONE after the last strobe; 482 bytes consumed.
REQ-043 User, 4-bit: LOADTYPE=1, BITWIDTH4=1 -> first strobe address 28672, last 31007, 292 bytes consumed, no partial byte.
REQ-044 Backpressure: BYTEVALID toggled with gaps of 0-5 cycles -> strobe addresses remain contiguous, no strobe occurs while waiting, byte order preserved.
REQ-045 Abort: LOADABORT during the 3rd bit of byte 10 -> strobes stop next cycle, LOADBUSY=0, no LOADDONE; a following LOADSTART restarts at address 0.
REQ-046 Reset: nRESET pulsed low mid-SHIFT -> outputs take reset values immediately without waiting for a clock edge; LOADSTART during busy is ignored (no address restart observed).
